// File: rtl/dvi_capture_if.sv
// Stream-in / frame-buffer-out bundle for the DVI capture sink.
// The master side drives the pixel stream and observes writes. The slave side is the capture block.
interface dvi_capture_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic              hsync;
  logic              vsync;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;

  modport master (
    output red, green, blue, hsync, vsync,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  red, green, blue, hsync, vsync,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/dvi_capture.sv
// Captures an hsync/vsync-framed RGB stream into a linear frame-buffer write port.
// It also reports frame completion, the captured line count and sticky protocol errors.
module dvi_capture #(
  parameter int H_ACTIVE = 10,
  parameter int V_ACTIVE = 10,
  parameter int ADDR_W   = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  dvi_capture_if.slave bus,
  output logic         frame_done,
  output logic [9:0]   lines_captured,
  output logic         busy,
  output logic         err_short,
  output logic         err_long,
  output logic         err_extra
);

  localparam int PW = $clog2(H_ACTIVE + 1);

  typedef enum logic [2:0] {IDLE, WAIT_LINE, LINE, GAP, DONE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     pixel_cnt_q, pixel_cnt_d;
  logic [9:0]        line_cnt_q, line_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [23:0]       wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;
  logic              err_short_q, err_short_d;
  logic              err_long_q, err_long_d;
  logic              err_extra_q, err_extra_d;
  logic              extra_q, extra_d;

  logic              at_last_line;
  logic              last_pixel;
  logic [ADDR_W-1:0] line_base;

  assign at_last_line = (line_cnt_q == 10'(V_ACTIVE));
  assign last_pixel   = (pixel_cnt_q == PW'(H_ACTIVE - 1));
  // Base address comes from the line index, so a short line never shifts the lines after it.
  assign line_base    = ADDR_W'(int'(line_cnt_q) * H_ACTIVE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      pixel_cnt_q  <= '0;
      line_cnt_q   <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      err_short_q  <= 1'b0;
      err_long_q   <= 1'b0;
      err_extra_q  <= 1'b0;
      extra_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pixel_cnt_q  <= pixel_cnt_d;
      line_cnt_q   <= line_cnt_d;
      addr_q       <= addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      err_short_q  <= err_short_d;
      err_long_q   <= err_long_d;
      err_extra_q  <= err_extra_d;
      extra_q      <= extra_d;
    end
  end

  // vsync has priority over hsync everywhere a frame is in progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = WAIT_LINE;
      WAIT_LINE: begin
        if (bus.vsync)      state_d = DONE;
        else if (bus.hsync) state_d = LINE;
      end
      LINE: begin
        if (bus.vsync)      state_d = DONE;
        else if (bus.hsync) state_d = at_last_line ? GAP : LINE;
        else if (last_pixel) state_d = GAP;
      end
      GAP: begin
        if (bus.vsync)                       state_d = DONE;
        else if (bus.hsync && !at_last_line) state_d = LINE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pixel_cnt_d  = pixel_cnt_q;
    line_cnt_d   = line_cnt_q;
    addr_d       = addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    err_short_d  = err_short_q;
    err_long_d   = err_long_q;
    err_extra_d  = err_extra_q;
    extra_d      = extra_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pixel_cnt_d = '0;
          line_cnt_d  = '0;
          addr_d      = '0;
          err_short_d = 1'b0;
          err_long_d  = 1'b0;
          err_extra_d = 1'b0;
          extra_d     = 1'b0;
        end
      end
      WAIT_LINE: begin
        if (bus.vsync) begin
          frame_done_d = 1'b1;
        end else if (bus.hsync) begin
          line_cnt_d  = 10'd1;
          pixel_cnt_d = '0;
          addr_d      = '0;
        end
      end
      LINE, GAP: begin
        if (bus.vsync) begin
          frame_done_d = 1'b1;
          if (state_q == LINE && pixel_cnt_q != '0) err_short_d = 1'b1;
        end else if (bus.hsync) begin
          if (state_q == LINE) err_short_d = 1'b1;
          // A line beyond the frame is flagged and swallowed until vsync.
          if (at_last_line) begin
            err_extra_d = 1'b1;
            extra_d     = 1'b1;
          end else begin
            line_cnt_d  = line_cnt_q + 10'd1;
            pixel_cnt_d = '0;
            addr_d      = line_base;
          end
        end else if (state_q == LINE) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = addr_q;
          wr_data_d   = {bus.red, bus.green, bus.blue};
          pixel_cnt_d = pixel_cnt_q + PW'(1);
          addr_d      = addr_q + ADDR_W'(1);
        end else if (!extra_q) begin
          err_long_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy_d = (state_d == WAIT_LINE) || (state_d == LINE) || (state_d == GAP);
  end

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign frame_done     = frame_done_q;
  assign lines_captured = line_cnt_q;
  assign busy           = busy_q;
  assign err_short      = err_short_q;
  assign err_long       = err_long_q;
  assign err_extra      = err_extra_q;

endmodule

// File: doc/dvi_capture.md
Name: dvi_capture

Overview:
- Downstream consumer of the DVI stimulus/pixel-stream stage. Takes the red/green/blue/hsync/vsync stream and writes each active pixel into a frame-buffer write port as packed 24-bit RGB at a linear address.
- Reports frame completion, the number of captured lines, and sticky protocol errors (short/long line, extra line).
- Used as the checker/sink in the display bring-up path.

Parameters:
- H_ACTIVE, 10, pixels per line to capture.
- V_ACTIVE, 10, lines per frame to capture.
- ADDR_W, 8, frame-buffer address width. Requires H_ACTIVE*V_ACTIVE <= 2^ADDR_W.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  arm capture; honoured only in IDLE or DONE
- red  in  8  pixel red
- green  in  8  pixel green
- blue  in  8  pixel blue
- hsync  in  1  line-start pulse, active-high
- vsync  in  1  frame-end marker, active-high
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  write address = line*H_ACTIVE + pixel
- wr_data  out  24  {red,green,blue}
- frame_done  out  1  one-cycle pulse on frame end
- lines_captured  out  10  lines started this frame, saturates at V_ACTIVE
- busy  out  1  high in WAIT_LINE/LINE/GAP
- err_short  out  1  sticky: line ended with < H_ACTIVE pixels
- err_long  out  1  sticky: pixel arrived after H_ACTIVE reached
- err_extra  out  1  sticky: hsync arrived with V_ACTIVE lines already started

Behaviour:
- Reset: state IDLE; all outputs 0; pixel and line counters 0; address 0. Reset mid-frame aborts with no frame_done.
- Stream protocol: a cycle with hsync=1 starts a line and carries no pixel. Every subsequent hsync=0, vsync=0 cycle is one pixel. vsync=1 ends the frame. No blanking cycles exist.
- All outputs are registered. A pixel sampled at edge N gives wr_en=1 with its addr/data valid in the cycle after edge N, i.e. latency 1. wr_en is otherwise 0.
- States:
  - IDLE: start -> WAIT_LINE; clears errors, counters, lines_captured.
  - WAIT_LINE: hsync -> LINE, line counter = 1. hsync=0 cycles are ignored.
  - LINE: each pixel writes, then pixel_cnt++ and addr++. After the H_ACTIVE-th pixel -> GAP. An hsync while pixel_cnt < H_ACTIVE sets err_short, starts a new line, pixel_cnt=0, and sets addr = line*H_ACTIVE.
  - GAP: a pixel cycle sets err_long with no write. hsync -> LINE for the next line.
  - DONE: hold outputs, frame_done=0. start re-arms and behaves as start in IDLE.
- Extra line: an hsync when lines_captured==V_ACTIVE sets err_extra. That line's pixels are not written; state stays GAP until vsync.
- vsync in WAIT_LINE/LINE/GAP -> DONE with frame_done=1 for exactly one cycle.
  - If in LINE with 0 < pixel_cnt < H_ACTIVE, also set err_short.
  - vsync in IDLE or DONE is ignored.
- Simultaneous hsync and vsync: vsync wins; the line is not started.
- Simultaneous start and reset: reset wins.
- Address never wraps. The write address is computed from the line counter, not free-running, so a short line does not shift later lines.
- Colour values are passed unmodified. No arithmetic is done on pixel data.

Test Plan:
- Nominal frame, defaults. Stimulus: start; then 10x (hsync pulse + 10 pixels with red=line, green=pixel, blue=0xFF); then vsync. Required: exactly 100 writes at addr 0..99, each with wr_data={line,pixel,0xFF}; frame_done pulses once; lines_captured=10; all errors 0.
- Short line. Stimulus: line 2 has 7 pixels, then hsync. Required: err_short=1; line 3 pixel 0 is written at addr 30; 97 writes in total.
- Long line. Stimulus: line 0 has 12 pixels. Required: writes at addr 0..9 only; err_long=1; line 1 starts at addr 10.
- Extra line plus simultaneous events. Stimulus: 11 lines of 10 pixels, then hsync and vsync in the same cycle. Required: err_extra=1; 100 writes; frame_done pulses in the cycle after vsync is sampled; lines_captured=10.
- Reset mid-frame. Stimulus: reset during line 4. Required: next cycle all outputs 0 and state IDLE; pixels are ignored until start.
- Re-arm. Stimulus: start in DONE with errors set. Required: errors clear, busy=1, next frame begins at addr 0.
